regfile_writeback: RTL and testbench
====================================

# regfile_writeback

Write-port arbiter and buffer that drives the single write port (`RegWrite`/`WriteReg`/`WriteData`) of the 32×32-bit register file. It merges two result sources into one write per cycle:
- a single-cycle ALU result path, which has priority;
- a variable-latency memory/load return path, buffered in a small FIFO.

It discards writes to R0. It enforces a bounded wait for buffered loads, so the FIFO cannot starve behind the ALU.

## Interface
Parameters:
- `DEPTH`, 4: load FIFO entries; power of two, ≥2.
- `STARVE_LIMIT`, 3: consecutive cycles a FIFO head may lose to the ALU before the ALU is stalled; ≥1.

Ports:
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `alu_valid`  in  1  ALU result present.
- `alu_ready`  out  1  ALU result accepted this cycle when `alu_valid && alu_ready`.
- `alu_reg`  in  5  ALU destination register.
- `alu_data`  in  32  ALU result.
- `mem_valid`  in  1  load result present.
- `mem_ready`  out  1  load result accepted when `mem_valid && mem_ready`.
- `mem_reg`  in  5  load destination register.
- `mem_data`  in  32  load data.
- `RegWrite`  out  1  register-file write enable.
- `WriteReg`  out  5  register-file write address.
- `WriteData`  out  32  register-file write data.
- `fifo_count`  out  $clog2(DEPTH)+1  current FIFO occupancy.
- `query_reg1`  in  5  hazard query address 1.
- `query_reg2`  in  5  hazard query address 2.
- `busy1`  out  1  write pending to `query_reg1`.
- `busy2`  out  1  write pending to `query_reg2`.

## Operation
- FIFO: circular buffer of `DEPTH` entries {reg[4:0], data[31:0]}, with read/write pointers and an occupancy counter.
- Load acceptance:
  - `mem_ready = !reset && (fifo_count < DEPTH)`.
  - An accepted load with `mem_reg != 0` is pushed.
  - An accepted load with `mem_reg == 0` completes the handshake but is not pushed.
- Starvation counter `age`:
  - Increments each cycle the FIFO is non-empty and the head is not popped.
  - Clears on a pop, or when the FIFO is empty.
  - Saturates at `STARVE_LIMIT`.
- `alu_ready = !reset && (age < STARVE_LIMIT)`.
- Write arbitration, evaluated each cycle, at most one write:
  - If `alu_valid && alu_ready`: write the ALU result. The FIFO head is not popped.
  - Otherwise, if the FIFO is non-empty: pop the head and write it.
  - Otherwise: no write.
- An accepted ALU result with `alu_reg == 0` is consumed and produces no write. In that cycle the FIFO head may pop.
- Push and pop in the same cycle are legal at any occupancy below full; `fifo_count` is unchanged. When full, push is impossible because `mem_ready` is low.
- Pointers wrap modulo `DEPTH`.
- `busy1` and `busy2` are defined under Configuration.

## Timing
- All write-port outputs are registered.
- ALU accepted at cycle N → `RegWrite` high at N+1.
- Load pushed at cycle N → earliest pop at N+1 → `RegWrite` high at N+2 (FIFO never bypassed).
- `RegWrite` is high for exactly one cycle per write. `WriteReg`/`WriteData` hold their last value when `RegWrite` is low.
- Worst-case wait for a FIFO head under continuous ALU traffic is `STARVE_LIMIT` cycles. The next cycle is forced to a pop, with `alu_ready` low.
- Reset state:
  - `RegWrite`=0, `WriteReg`=0, `WriteData`=0.
  - `fifo_count`=0, pointers 0, `age`=0.
  - `alu_ready`=0 and `mem_ready`=0 while `reset` is high.
  - `busy1`/`busy2`=0.
- Reset asserted mid-operation discards all buffered entries and any pending write. The first accepted input after reset deasserts is at the first cycle with `reset` low.

## Configuration
- Macro `REGFILE_WB_SCOREBOARD_EN`.
- Defined: `busyN` is combinational and high when `query_regN != 0` and either:
  - any valid FIFO entry has reg == `query_regN`, or
  - (`RegWrite && WriteReg == query_regN`).
- Undefined: `busy1`/`busy2` are tied to 0 and the match logic is omitted. Ports remain present.

## Test plan
- Reset, then ALU write `alu_reg`=5, data 0xDEADBEEF → `RegWrite`=1, `WriteReg`=5, `WriteData`=0xDEADBEEF exactly one cycle later. No other write follows.
- Four loads (regs 1–4, data 0x11..0x44) with no ALU traffic → writes appear in order 1,2,3,4, the first two cycles after its push. `mem_ready` stays high because occupancy never reaches 4.
- Fill FIFO with 4 loads while ALU is continuously valid → `mem_ready` low at `fifo_count`=4. `alu_ready` drops after 3 cycles of head waiting. The head pops the next cycle and `mem_ready` returns high.
- ALU write and load both targeting R0 → handshakes complete. No `RegWrite` pulse, `fifo_count` stays 0.
- `reset` pulsed with 3 entries buffered → `fifo_count`=0, `RegWrite`=0 the cycle after. None of the 3 writes ever appear.
- With `REGFILE_WB_SCOREBOARD_EN`, load to R7 buffered and `query_reg1`=7, `query_reg2`=0 → `busy1`=1, `busy2`=0. `busy1` stays high through the write cycle and goes low the cycle after.

Source files
------------

// File: rtl/regfile_writeback.sv
// -----------------------------------------------------------------------------
// regfile_writeback
//
// Purpose:
//   Drives the single write port of the 32x32-bit register file. Two result
//   sources are merged into at most one write per cycle:
//     - the single-cycle ALU result path (priority), and
//     - a variable-latency load return path, buffered in a circular FIFO.
//   Writes to R0 are dropped. A starvation counter ("age") bounds how long the
//   FIFO head may lose to the ALU; once it saturates the ALU is held off for
//   one cycle so the head is written.
//
// Parameters:
//   DEPTH         load FIFO entries (power of two, >= 2)
//   STARVE_LIMIT  cycles a FIFO head may lose to the ALU before the ALU stalls
//
// Ports:
//   clock                 rising-edge clock
//   reset                 synchronous, active-high reset
//   alu_valid/alu_ready   ALU result handshake; alu_reg/alu_data = payload
//   mem_valid/mem_ready   load return handshake; mem_reg/mem_data = payload
//   RegWrite              registered register-file write enable (1-cycle pulse)
//   WriteReg/WriteData    registered write address/data (hold when idle)
//   fifo_count            current load FIFO occupancy
//   query_reg1/2          hazard query addresses
//   busy1/busy2           write pending to query_reg1/2
//
// Optional feature:
//   REGFILE_WB_SCOREBOARD_EN - when defined, busy1/busy2 report whether a write
//   to the queried register is still buffered in the FIFO or is on the write
//   port this cycle. When undefined, busy1/busy2 are tied low.
// -----------------------------------------------------------------------------
module regfile_writeback #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     alu_valid,
    output logic                     alu_ready,
    input  logic [4:0]               alu_reg,
    input  logic [31:0]              alu_data,
    input  logic                     mem_valid,
    output logic                     mem_ready,
    input  logic [4:0]               mem_reg,
    input  logic [31:0]              mem_data,
    output logic                     RegWrite,
    output logic [4:0]               WriteReg,
    output logic [31:0]              WriteData,
    output logic [$clog2(DEPTH):0]   fifo_count,
    input  logic [4:0]               query_reg1,
    input  logic [4:0]               query_reg2,
    output logic                     busy1,
    output logic                     busy2
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int GW = $clog2(STARVE_LIMIT + 1);

    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [AW-1:0] PTR_ZERO  = AW'(0);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [GW-1:0] AGE_ZERO  = GW'(0);
    localparam logic [GW-1:0] AGE_ONE   = GW'(1);
    localparam logic [GW-1:0] AGE_LIMIT = GW'(STARVE_LIMIT);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [4:0]    reg_mem_q  [DEPTH];
    logic [31:0]   data_mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [GW-1:0] age_q, age_d;
    logic          reg_write_q, reg_write_d;
    logic [4:0]    write_reg_q, write_reg_d;
    logic [31:0]   write_data_q, write_data_d;

    // ------------------------------------------------------------------
    // Combinational handshake / arbitration signals
    // ------------------------------------------------------------------
    logic          fifo_empty_s;
    logic          mem_ready_s;
    logic          alu_ready_s;
    logic          alu_fire_s;
    logic          alu_write_s;
    logic          push_s;
    logic          pop_s;
    logic [4:0]    head_reg_s;
    logic [31:0]   head_data_s;

    // Handshakes and the single-write arbitration decision for this cycle.
    always_comb begin
        fifo_empty_s = (count_q == CNT_ZERO);
        mem_ready_s  = !reset && (count_q < DEPTH_C);
        // Once the head has waited STARVE_LIMIT cycles the ALU is held off.
        alu_ready_s  = !reset && (age_q < AGE_LIMIT);
        alu_fire_s   = alu_valid && alu_ready_s;
        // An accepted ALU result to R0 is consumed silently and leaves the
        // write port free, so the FIFO head can still pop in that cycle.
        alu_write_s  = alu_fire_s && (alu_reg != 5'd0);
        // Loads to R0 complete their handshake but never occupy a slot.
        push_s       = mem_valid && mem_ready_s && (mem_reg != 5'd0);
        pop_s        = !fifo_empty_s && !alu_write_s;
        head_reg_s   = reg_mem_q[rd_ptr_q];
        head_data_s  = data_mem_q[rd_ptr_q];
    end

    // FIFO pointer, occupancy and starvation-age next state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        age_d    = age_q;

        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        // Simultaneous push and pop leaves the occupancy unchanged.
        if (push_s && !pop_s) begin
            count_d = count_q + CNT_ONE;
        end else if (pop_s && !push_s) begin
            count_d = count_q - CNT_ONE;
        end else begin
            count_d = count_q;
        end

        // Age tracks how long the current head has been passed over; it is
        // judged on the occupancy before this cycle's push.
        if (fifo_empty_s || pop_s) begin
            age_d = AGE_ZERO;
        end else if (age_q < AGE_LIMIT) begin
            age_d = age_q + AGE_ONE;
        end else begin
            age_d = age_q;
        end
    end

    // Write-port next state: ALU has priority, otherwise the popped FIFO head.
    always_comb begin
        reg_write_d  = 1'b0;
        write_reg_d  = write_reg_q;
        write_data_d = write_data_q;

        if (alu_write_s) begin
            reg_write_d  = 1'b1;
            write_reg_d  = alu_reg;
            write_data_d = alu_data;
        end else if (pop_s) begin
            reg_write_d  = 1'b1;
            write_reg_d  = head_reg_s;
            write_data_d = head_data_s;
        end else begin
            // Address and data hold their last value while no write occurs.
            reg_write_d  = 1'b0;
            write_reg_d  = write_reg_q;
            write_data_d = write_data_q;
        end
    end

    // Control and write-port registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q     <= PTR_ZERO;
            rd_ptr_q     <= PTR_ZERO;
            count_q      <= CNT_ZERO;
            age_q        <= AGE_ZERO;
            reg_write_q  <= 1'b0;
            write_reg_q  <= 5'd0;
            write_data_q <= 32'd0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            age_q        <= age_d;
            reg_write_q  <= reg_write_d;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
        end
    end

    // FIFO storage; cleared on reset so no stale entry is ever observable.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                reg_mem_q[i]  <= 5'd0;
                data_mem_q[i] <= 32'd0;
            end
        end else if (push_s) begin
            reg_mem_q[wr_ptr_q]  <= mem_reg;
            data_mem_q[wr_ptr_q] <= mem_data;
        end else begin
            reg_mem_q[wr_ptr_q]  <= reg_mem_q[wr_ptr_q];
            data_mem_q[wr_ptr_q] <= data_mem_q[wr_ptr_q];
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign alu_ready  = alu_ready_s;
    assign mem_ready  = mem_ready_s;
    assign RegWrite   = reg_write_q;
    assign WriteReg   = write_reg_q;
    assign WriteData  = write_data_q;
    assign fifo_count = count_q;

`ifdef REGFILE_WB_SCOREBOARD_EN
    // ------------------------------------------------------------------
    // Pending-write scoreboard
    // ------------------------------------------------------------------
    logic [DEPTH-1:0] entry_valid_s;
    logic             busy1_s;
    logic             busy2_s;

    // Distance of a storage slot from the head, modulo DEPTH.
    function automatic logic [AW-1:0] ring_offset(input logic [AW-1:0] idx,
                                                  input logic [AW-1:0] base);
        return idx - base;
    endfunction

    // A query matches a live FIFO entry or the write currently on the port.
    function automatic logic pending_match(input logic [4:0] query);
        logic hit;
        hit = reg_write_q && (write_reg_q == query);
        for (int i = 0; i < DEPTH; i++) begin
            hit = hit | (entry_valid_s[i] && (reg_mem_q[i] == query));
        end
        return (query != 5'd0) && hit;
    endfunction

    // Mark slots holding live entries: those within 'count' places of the head.
    always_comb begin
        entry_valid_s = {DEPTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            entry_valid_s[i] = ({1'b0, ring_offset(AW'(i), rd_ptr_q)} < count_q);
        end
    end

    // Hazard lookup for both query ports.
    always_comb begin
        busy1_s = pending_match(query_reg1);
        busy2_s = pending_match(query_reg2);
    end

    assign busy1 = busy1_s;
    assign busy2 = busy2_s;
`else
    // Scoreboard not built: query inputs are intentionally ignored.
    logic unused_query_s;
    assign unused_query_s = ^{query_reg1, query_reg2};
    assign busy1 = 1'b0;
    assign busy2 = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
module tb_regfile_writeback;

    localparam int DEPTH        = 4;
    localparam int STARVE_LIMIT = 3;
    localparam int CW           = $clog2(DEPTH) + 1;
`ifdef REGFILE_WB_SCOREBOARD_EN
    localparam bit SB_EN = 1'b1;
`else
    localparam bit SB_EN = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset;
    logic          alu_valid, alu_ready;
    logic [4:0]    alu_reg;
    logic [31:0]   alu_data;
    logic          mem_valid, mem_ready;
    logic [4:0]    mem_reg;
    logic [31:0]   mem_data;
    logic          RegWrite;
    logic [4:0]    WriteReg;
    logic [31:0]   WriteData;
    logic [CW-1:0] fifo_count;
    logic [4:0]    query_reg1, query_reg2;
    logic          busy1, busy2;

    always #5 clock = ~clock;

    regfile_writeback #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clock(clock), .reset(reset),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_reg(alu_reg), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_reg(mem_reg), .mem_data(mem_data),
        .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
        .fifo_count(fifo_count),
        .query_reg1(query_reg1), .query_reg2(query_reg2), .busy1(busy1), .busy2(busy2)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: queue of pending loads {reg, data}, head wait age, write port.
    logic [36:0] exp_q[$];
    int          exp_age   = 0;
    logic        exp_we    = 1'b0;
    logic [4:0]  exp_wreg  = 5'd0;
    logic [31:0] exp_wdata = 32'd0;

    function automatic logic exp_alu_ready();
        return !reset && (exp_age < STARVE_LIMIT);
    endfunction

    function automatic logic exp_mem_ready();
        return !reset && (exp_q.size() < DEPTH);
    endfunction

    function automatic logic exp_busy(input logic [4:0] q);
        logic hit;
        hit = exp_we && (exp_wreg == q);
        foreach (exp_q[i]) hit = hit | (exp_q[i][36:32] == q);
        return SB_EN && (q != 5'd0) && hit;
    endfunction

    // Advance the model by one clock using the inputs currently driven, then clock the DUT.
    task automatic tick();
        logic        alu_wr, pop, push;
        logic [36:0] head;
        if (reset) begin
            exp_q.delete();
            exp_age = 0; exp_we = 1'b0; exp_wreg = 5'd0; exp_wdata = 32'd0;
        end else begin
            alu_wr = alu_valid && (exp_age < STARVE_LIMIT) && (alu_reg != 5'd0);
            push   = mem_valid && (exp_q.size() < DEPTH) && (mem_reg != 5'd0);
            pop    = !alu_wr && (exp_q.size() > 0);
            if (exp_q.size() == 0 || pop) exp_age = 0;
            else if (exp_age < STARVE_LIMIT) exp_age = exp_age + 1;
            if (alu_wr) begin
                exp_we = 1'b1; exp_wreg = alu_reg; exp_wdata = alu_data;
            end else if (pop) begin
                head = exp_q.pop_front();
                exp_we = 1'b1; exp_wreg = head[36:32]; exp_wdata = head[31:0];
            end else begin
                exp_we = 1'b0;
            end
            if (push) exp_q.push_back({mem_reg, mem_data});
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0; alu_reg = 5'd0; alu_data = 32'd0;
        mem_valid = 1'b0; mem_reg = 5'd0; mem_data = 32'd0;
    endtask

    task automatic idle_cycles(input int n);
        idle_inputs();
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; idle_inputs(); query_reg1 = 5'd5; query_reg2 = 5'd9;
        #1;
        n_checks++; if (alu_ready !== 1'b0) begin n_errors++; $display("FAIL reset_alu_ready: got %b want 0", alu_ready); end
        n_checks++; if (mem_ready !== 1'b0) begin n_errors++; $display("FAIL reset_mem_ready: got %b want 0", mem_ready); end
        tick(); tick();
        n_checks++; if (RegWrite !== 1'b0) begin n_errors++; $display("FAIL reset_regwrite: got %b want 0", RegWrite); end
        n_checks++; if (WriteReg !== 5'd0) begin n_errors++; $display("FAIL reset_writereg: got %0d want 0", WriteReg); end
        n_checks++; if (WriteData !== 32'd0) begin n_errors++; $display("FAIL reset_writedata: got %h want 0", WriteData); end
        n_checks++; if (fifo_count !== CW'(0)) begin n_errors++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
        n_checks++; if ({busy1, busy2} !== 2'b00) begin n_errors++; $display("FAIL reset_busy: got %b%b want 00", busy1, busy2); end
        reset = 1'b0;
        #1;
        n_checks++; if (alu_ready !== 1'b1) begin n_errors++; $display("FAIL post_reset_alu_ready: got %b want 1", alu_ready); end
        n_checks++; if (mem_ready !== 1'b1) begin n_errors++; $display("FAIL post_reset_mem_ready: got %b want 1", mem_ready); end
    endtask

    task automatic test_alu_single();
        alu_valid = 1'b1; alu_reg = 5'd5; alu_data = 32'hDEADBEEF;
        #1;
        n_checks++; if (alu_ready !== 1'b1) begin n_errors++; $display("FAIL alu_ready: got %b want 1", alu_ready); end
        tick();
        idle_inputs();
        n_checks++; if (RegWrite !== 1'b1) begin n_errors++; $display("FAIL alu_regwrite: got %b want 1", RegWrite); end
        n_checks++; if (WriteReg !== 5'd5) begin n_errors++; $display("FAIL alu_writereg: got %0d want 5", WriteReg); end
        n_checks++; if (WriteData !== 32'hDEADBEEF) begin n_errors++; $display("FAIL alu_writedata: got %h want deadbeef", WriteData); end
        tick();
        n_checks++; if (RegWrite !== 1'b0) begin n_errors++; $display("FAIL alu_single_pulse: got %b want 0", RegWrite); end
        n_checks++; if (WriteReg !== 5'd5) begin n_errors++; $display("FAIL alu_hold_reg: got %0d want 5", WriteReg); end
        n_checks++; if (WriteData !== 32'hDEADBEEF) begin n_errors++; $display("FAIL alu_hold_data: got %h want deadbeef", WriteData); end
        tick();
        n_checks++; if (RegWrite !== 1'b0) begin n_errors++; $display("FAIL alu_no_extra: got %b want 0", RegWrite); end
    endtask

    task automatic test_loads_in_order();
        logic [4:0]  want_reg;
        logic [31:0] want_data;
        for (int c = 0; c < 10; c++) begin
            if (c < 4) begin
                mem_valid = 1'b1; mem_reg = 5'(c + 1); mem_data = 32'(c + 1) * 32'h11;
            end else begin
                idle_inputs();
            end
            #1;
            if (c < 4) begin
                n_checks++; if (mem_ready !== 1'b1) begin n_errors++; $display("FAIL load_mem_ready c%0d: got %b want 1", c, mem_ready); end
            end
            tick();
            // Push in cycle k is written two cycles later: visible after tick k+1.
            if (c >= 1 && c <= 4) begin
                want_reg = 5'(c); want_data = 32'(c) * 32'h11;
                n_checks++; if (RegWrite !== 1'b1 || WriteReg !== want_reg || WriteData !== want_data) begin
                    n_errors++; $display("FAIL load_order c%0d: got we=%b reg=%0d data=%h want we=1 reg=%0d data=%h", c, RegWrite, WriteReg, WriteData, want_reg, want_data);
                end
            end else begin
                n_checks++; if (RegWrite !== 1'b0) begin n_errors++; $display("FAIL load_idle c%0d: got we=%b want 0", c, RegWrite); end
            end
            n_checks++; if (fifo_count !== CW'(exp_q.size())) begin n_errors++; $display("FAIL load_count c%0d: got %0d want %0d", c, fifo_count, exp_q.size()); end
        end
    endtask

    task automatic test_fill_starve();
        for (int c = 0; c < 12; c++) begin
            alu_valid = 1'b1; alu_reg = 5'($urandom_range(1, 31)); alu_data = $urandom;
            mem_valid = (c < 8); mem_reg = 5'(16 + c); mem_data = $urandom;
            #1;
            n_checks++; if (alu_ready !== exp_alu_ready() || mem_ready !== exp_mem_ready()) begin
                n_errors++; $display("FAIL starve_ready c%0d: got alu=%b mem=%b want alu=%b mem=%b", c, alu_ready, mem_ready, exp_alu_ready(), exp_mem_ready());
            end
            if (c == 4) begin
                n_checks++; if (fifo_count !== CW'(4) || mem_ready !== 1'b0 || alu_ready !== 1'b0) begin
                    n_errors++; $display("FAIL starve_full: got count=%0d mem=%b alu=%b want 4 0 0", fifo_count, mem_ready, alu_ready);
                end
            end
            if (c == 5) begin
                n_checks++; if (fifo_count !== CW'(3) || mem_ready !== 1'b1) begin
                    n_errors++; $display("FAIL starve_recover: got count=%0d mem=%b want 3 1", fifo_count, mem_ready);
                end
            end
            tick();
            if (c == 4) begin
                n_checks++; if (RegWrite !== 1'b1 || WriteReg !== 5'd16) begin
                    n_errors++; $display("FAIL starve_head_pop: got we=%b reg=%0d want 1 16", RegWrite, WriteReg);
                end
            end
            n_checks++; if (RegWrite !== exp_we || WriteReg !== exp_wreg || WriteData !== exp_wdata || fifo_count !== CW'(exp_q.size())) begin
                n_errors++; $display("FAIL starve_port c%0d: got we=%b reg=%0d data=%h cnt=%0d want we=%b reg=%0d data=%h cnt=%0d",
                    c, RegWrite, WriteReg, WriteData, fifo_count, exp_we, exp_wreg, exp_wdata, exp_q.size());
            end
        end
        idle_cycles(8);
        n_checks++; if (fifo_count !== CW'(0) || exp_q.size() != 0) begin n_errors++; $display("FAIL starve_drain: got %0d want 0", fifo_count); end
    endtask

    task automatic test_r0();
        alu_valid = 1'b1; alu_reg = 5'd0; alu_data = 32'hCAFEF00D;
        mem_valid = 1'b1; mem_reg = 5'd0; mem_data = 32'h12345678;
        #1;
        n_checks++; if (alu_ready !== 1'b1 || mem_ready !== 1'b1) begin n_errors++; $display("FAIL r0_handshake: got alu=%b mem=%b want 1 1", alu_ready, mem_ready); end
        tick();
        idle_inputs();
        for (int c = 0; c < 2; c++) begin
            n_checks++; if (RegWrite !== 1'b0 || fifo_count !== CW'(0)) begin
                n_errors++; $display("FAIL r0_dropped c%0d: got we=%b cnt=%0d want 0 0", c, RegWrite, fifo_count);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 4; c++) begin
            alu_valid = 1'b1; alu_reg = 5'($urandom_range(1, 31)); alu_data = $urandom;
            mem_valid = (c < 3); mem_reg = 5'(20 + c); mem_data = $urandom;
            tick();
        end
        idle_inputs();
        n_checks++; if (fifo_count !== CW'(3)) begin n_errors++; $display("FAIL midreset_buffered: got %0d want 3", fifo_count); end
        reset = 1'b1;
        #1;
        n_checks++; if (alu_ready !== 1'b0 || mem_ready !== 1'b0) begin n_errors++; $display("FAIL midreset_ready: got alu=%b mem=%b want 0 0", alu_ready, mem_ready); end
        tick();
        reset = 1'b0;
        n_checks++; if (fifo_count !== CW'(0) || RegWrite !== 1'b0) begin n_errors++; $display("FAIL midreset_clear: got cnt=%0d we=%b want 0 0", fifo_count, RegWrite); end
        for (int c = 0; c < 8; c++) begin
            tick();
            n_checks++; if (RegWrite !== 1'b0 || fifo_count !== CW'(0)) begin
                n_errors++; $display("FAIL midreset_ghost c%0d: got we=%b reg=%0d cnt=%0d want 0", c, RegWrite, WriteReg, fifo_count);
            end
        end
    endtask

    task automatic test_scoreboard();
        query_reg1 = 5'd7; query_reg2 = 5'd0;
        mem_valid = 1'b1; mem_reg = 5'd7; mem_data = 32'h00000777;
        #1;
        n_checks++; if (busy1 !== 1'b0) begin n_errors++; $display("FAIL sb_before_push: got %b want 0", busy1); end
        tick();
        idle_inputs();
        #1;
        n_checks++; if (busy1 !== SB_EN || busy2 !== 1'b0) begin n_errors++; $display("FAIL sb_buffered: got %b%b want %b0", busy1, busy2, SB_EN); end
        tick();
        n_checks++; if (RegWrite !== 1'b1 || WriteReg !== 5'd7 || busy1 !== SB_EN) begin
            n_errors++; $display("FAIL sb_write_cycle: got we=%b reg=%0d busy1=%b want 1 7 %b", RegWrite, WriteReg, busy1, SB_EN);
        end
        tick();
        n_checks++; if (busy1 !== 1'b0 || RegWrite !== 1'b0) begin n_errors++; $display("FAIL sb_after_write: got busy1=%b we=%b want 0 0", busy1, RegWrite); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            reset      = ($urandom_range(0, 63) == 0);
            alu_valid  = ($urandom_range(0, 3) != 0);
            alu_reg    = 5'($urandom_range(0, 7)); alu_data = $urandom;
            mem_valid  = ($urandom_range(0, 4) < 3);
            mem_reg    = 5'($urandom_range(0, 7)); mem_data = $urandom;
            query_reg1 = 5'($urandom_range(0, 7)); query_reg2 = 5'($urandom_range(0, 7));
            #1;
            n_checks++; if (alu_ready !== exp_alu_ready() || mem_ready !== exp_mem_ready()) begin
                n_errors++; $display("FAIL rand_ready c%0d: got alu=%b mem=%b want alu=%b mem=%b", c, alu_ready, mem_ready, exp_alu_ready(), exp_mem_ready());
            end
            n_checks++; if (busy1 !== exp_busy(query_reg1) || busy2 !== exp_busy(query_reg2)) begin
                n_errors++; $display("FAIL rand_busy c%0d: got %b%b want %b%b", c, busy1, busy2, exp_busy(query_reg1), exp_busy(query_reg2));
            end
            tick();
            n_checks++; if (RegWrite !== exp_we || WriteReg !== exp_wreg || WriteData !== exp_wdata || fifo_count !== CW'(exp_q.size())) begin
                n_errors++; $display("FAIL rand_port c%0d: got we=%b reg=%0d data=%h cnt=%0d want we=%b reg=%0d data=%h cnt=%0d",
                    c, RegWrite, WriteReg, WriteData, fifo_count, exp_we, exp_wreg, exp_wdata, exp_q.size());
            end
        end
        reset = 1'b0;
        idle_cycles(2);
    endtask

    initial begin
        reset = 1'b1; idle_inputs(); query_reg1 = 5'd0; query_reg2 = 5'd0;
        test_reset();
        test_alu_single();
        test_loads_in_order();
        test_fill_starve();
        test_r0();
        test_reset_mid();
        test_scoreboard();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
